xcvr_prbs_checker: RTL and testbench
====================================

Name: xcvr_prbs_checker

Overview:
- Receive-side checker for the transceiver link tests; the counterpart of the per-lane PRBS generator that drives the QSFP and SDI native PHY TX parallel data.
- Sits on the rx_parallel_data output of each xcvr_native_s10 instance and self-synchronises to the incoming PRBS stream.
- Declares lock once the stream is stable, then counts bit errors and checked words for readout over the status interconnect.
- One instance per lane; no seed exchange with the transmitter.

Parameters:
- DATA_W, 32, parallel word width; legal range 32..64.
- PRBS_SEL, 31, polynomial: 31 = x^31+x^28+1, 7 = x^7+x^6+1.
- LOCK_CNT, 16, consecutive error-free words needed to enter LOCKED (range 1..255).
- UNLOCK_CNT, 4, consecutive errored words needed to leave LOCKED (range 1..255).

Ports:
- clk  in  1  Recovered RX parallel clock (one clock only).
- reset_n  in  1  Asynchronous, active-low reset.
- rx_data  in  DATA_W  Received word. Bit 0 is the earliest bit on the serial line.
- rx_valid  in  1  rx_data is qualified this cycle.
- clear  in  1  Synchronous pulse: zero the counters and the sticky flag, return the FSM to HUNT.
- locked  out  1  FSM is in LOCKED.
- err_pulse  out  1  A word checked while LOCKED had at least one error.
- err_cnt  out  32  Saturating count of mismatched bits seen while LOCKED.
- word_cnt  out  32  Saturating count of words checked while LOCKED.
- lock_lost  out  1  Sticky: LOCKED→HUNT transition has occurred since reset or clear.

Behaviour:
- Reset (async, reset_n=0):
  - FSM = HUNT.
  - hist_valid = 0; history register = 0.
  - All outputs = 0.
- Self-synchronous check, taps (A,B) = (31,28) or (7,6):
  - Treat the previous valid word and the current word as one stream s[] in serial order.
  - For each bit n of the current word: mask[n] = s[n] ^ s[n-A] ^ s[n-B].
  - Compute the mask combinationally.
  - Register the mask, its popcount (width clog2(DATA_W+1)) and a nonzero flag.
  - Check latency: 1 cycle after the rx_valid word.
- History register:
  - Updated only on rx_valid.
  - The first valid word after reset or clear sets hist_valid=1, is not checked and produces no mask.
  - rx_valid=0 cycles freeze all state; gaps do not break the history.
- FSM, evaluated on each registered check result (the valid word only):
  - HUNT: a clean word moves to CHECK with good_cnt=1; an errored word stays in HUNT. When LOCK_CNT=1, a clean word goes directly to LOCKED.
  - CHECK: a clean word increments good_cnt; when good_cnt reaches LOCK_CNT, go to LOCKED. An errored word returns to HUNT with good_cnt=0.
  - LOCKED: an errored word increments bad_cnt; a clean word resets bad_cnt=0. When bad_cnt reaches UNLOCK_CNT, go to HUNT and set lock_lost=1.
- Counters:
  - Update only on words checked while the FSM is LOCKED at check time, including the word that causes unlock.
  - word_cnt += 1; err_cnt += popcount.
  - Both saturate at 0xFFFFFFFF with no wrap. Additions that overflow clamp to the maximum.
- err_pulse: 1-cycle pulse, registered alongside the counter update.
- locked: registered copy of the FSM state.
- One injected bit error produces 3 mask bits for PRBS31, possibly split across two consecutive words. This is the intended raw count; no correction is applied.
- clear:
  - Has priority over a simultaneous check result.
  - Next cycle: counters=0, lock_lost=0, FSM=HUNT, hist_valid=0.
- All-zero input stream: checks clean and would lock. Add a zero-run guard: in HUNT/CHECK, an all-zero rx_data word counts as errored.

Decomposition:
- Package xcvr_test_pkg, holding:
  - the FSM state enum (HUNT, CHECK, LOCKED);
  - the polynomial tap constants per PRBS_SEL;
  - the counter width constant (32).
- One sub-module: prbs_err_mask, which computes the combinational mask and popcount from {prev, cur}, parameterised by DATA_W and PRBS_SEL.

Test Plan:
- Clean stream: PRBS31, DATA_W=32, 100 valid words from an arbitrary seed.
  - locked rises after word 1+16 (one check cycle later).
  - err_cnt=0; word_cnt = number of words checked after lock.
- Single-bit flip: flip bit 5 of one word while LOCKED.
  - err_cnt=3; err_pulse high for 1 or 2 cycles.
  - locked stays 1.
- Loss of lock: replace the stream with random data for 4 words.
  - locked falls after the 4th errored check; lock_lost=1.
  - Relock after 16 clean words; lock_lost stays 1.
- Valid gaps: insert rx_valid=0 gaps of 1–10 cycles in a clean stream.
  - No errors counted; lock is held.
- clear while LOCKED, asserted together with an errored word:
  - Next cycle: err_cnt=0, word_cnt=0, lock_lost=0, locked=0.
  - The errored word is not counted.
- Saturation and reset:
  - Preload near saturation via a force, or use PRBS7 with all-ones corruption: err_cnt holds at 0xFFFFFFFF.
  - Asserting reset_n=0 mid-stream immediately zeroes all outputs.

Source files
------------

// File: rtl/xcvr_test_pkg.sv
// Shared types and constants for the transceiver PRBS link-test blocks.
// Holds the lock FSM encoding, polynomial taps and status counter width.
package xcvr_test_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    localparam int CNT_W   = 32;
    localparam int TAP31_A = 31;
    localparam int TAP31_B = 28;
    localparam int TAP7_A  = 7;
    localparam int TAP7_B  = 6;

    function automatic int tap_a(input int sel);
        return (sel == 7) ? TAP7_A : TAP31_A;
    endfunction

    function automatic int tap_b(input int sel);
        return (sel == 7) ? TAP7_B : TAP31_B;
    endfunction

endpackage

// File: rtl/prbs_err_mask.sv
// Combinational self-synchronous PRBS error mask over {current, previous}.
// Bit 0 of each word is the earliest serial bit.
module prbs_err_mask
    import xcvr_test_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int PRBS_SEL = 31,
    parameter int PC_W     = $clog2(DATA_W + 1)
) (
    input  logic [DATA_W-1:0] i_prev,
    input  logic [DATA_W-1:0] i_cur,
    output logic [DATA_W-1:0] o_mask,
    output logic [PC_W-1:0]   o_popcnt
);

    localparam int A = tap_a(PRBS_SEL);
    localparam int B = tap_b(PRBS_SEL);

    logic [2*DATA_W-1:0] w_s;

    assign w_s = {i_cur, i_prev};

    always_comb begin
        o_mask   = '0;
        o_popcnt = '0;
        for (int n = 0; n < DATA_W; n++) begin
            o_mask[n] = w_s[DATA_W+n] ^ w_s[DATA_W+n-A] ^ w_s[DATA_W+n-B];
        end
        for (int n = 0; n < DATA_W; n++) begin
            o_popcnt = o_popcnt + PC_W'(o_mask[n]);
        end
    end

endmodule

// File: rtl/xcvr_prbs_checker.sv
// Per-lane receive PRBS checker: self-synchronises, locks, and counts
// bit errors and checked words with saturating status counters.
module xcvr_prbs_checker
    import xcvr_test_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int PRBS_SEL   = 31,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              clear,
    output logic              locked,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              lock_lost
);

    localparam int PC_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_hist;
    logic              r_hist_valid;
    logic              r_chk_vld;
    logic [DATA_W-1:0] r_mask;
    logic [PC_W-1:0]   r_popcnt;
    logic              r_zero;
    lock_state_t       r_state;
    logic [7:0]        r_good;
    logic [7:0]        r_bad;
    logic              r_locked;
    logic              r_err_pulse;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [CNT_W-1:0]  r_word_cnt;
    logic              r_lock_lost;

    logic [DATA_W-1:0] w_mask;
    logic [PC_W-1:0]   w_popcnt;
    logic              w_word_bad;
    logic [8:0]        w_good_inc;
    logic [8:0]        w_bad_inc;
    logic [CNT_W:0]    w_err_sum;
    logic [CNT_W-1:0]  w_err_next;
    logic [CNT_W-1:0]  w_word_next;

    prbs_err_mask #(
        .DATA_W   (DATA_W),
        .PRBS_SEL (PRBS_SEL),
        .PC_W     (PC_W)
    ) u_mask (
        .i_prev   (r_hist),
        .i_cur    (rx_data),
        .o_mask   (w_mask),
        .o_popcnt (w_popcnt)
    );

    // The zero-run guard stops an idle all-zero lane from ever locking.
    assign w_word_bad  = (|r_mask) || ((r_state != LOCKED) && r_zero);
    assign w_good_inc  = {1'b0, r_good} + 9'd1;
    assign w_bad_inc   = {1'b0, r_bad} + 9'd1;
    assign w_err_sum   = {1'b0, r_err_cnt} + (CNT_W + 1)'(r_popcnt);
    assign w_err_next  = w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
    assign w_word_next = (&r_word_cnt) ? r_word_cnt : r_word_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hist       <= '0;
            r_hist_valid <= 1'b0;
            r_chk_vld    <= 1'b0;
            r_mask       <= '0;
            r_popcnt     <= '0;
            r_zero       <= 1'b0;
        end else if (clear) begin
            r_hist       <= '0;
            r_hist_valid <= 1'b0;
            r_chk_vld    <= 1'b0;
        end else begin
            r_chk_vld <= 1'b0;
            if (rx_valid) begin
                r_hist       <= rx_data;
                r_hist_valid <= 1'b1;
                if (r_hist_valid) begin
                    r_chk_vld <= 1'b1;
                    r_mask    <= w_mask;
                    r_popcnt  <= w_popcnt;
                    r_zero    <= (rx_data == '0);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= HUNT;
            r_good      <= '0;
            r_bad       <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
            r_word_cnt  <= '0;
            r_lock_lost <= 1'b0;
        end else if (clear) begin
            r_state     <= HUNT;
            r_good      <= '0;
            r_bad       <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
            r_word_cnt  <= '0;
            r_lock_lost <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (r_chk_vld) begin
                unique case (r_state)
                    HUNT: begin
                        if (!w_word_bad) begin
                            r_good <= 8'd1;
                            if (LOCK_CNT == 1) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                                r_bad    <= '0;
                            end else begin
                                r_state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (w_word_bad) begin
                            r_state <= HUNT;
                            r_good  <= '0;
                        end else if (w_good_inc >= 9'(LOCK_CNT)) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                            r_bad    <= '0;
                        end else begin
                            r_good <= w_good_inc[7:0];
                        end
                    end
                    LOCKED: begin
                        r_word_cnt  <= w_word_next;
                        r_err_cnt   <= w_err_next;
                        r_err_pulse <= w_word_bad;
                        if (!w_word_bad) begin
                            r_bad <= '0;
                        end else if (w_bad_inc >= 9'(UNLOCK_CNT)) begin
                            r_state     <= HUNT;
                            r_locked    <= 1'b0;
                            r_lock_lost <= 1'b1;
                            r_bad       <= '0;
                            r_good      <= '0;
                        end else begin
                            r_bad <= w_bad_inc[7:0];
                        end
                    end
                    default: begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;
    assign word_cnt  = r_word_cnt;
    assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_xcvr_prbs_checker.sv
// Bench for xcvr_prbs_checker: PRBS31 stream source plus a word-level
// reference model of sync, lock and saturating counters.
module tb_xcvr_prbs_checker;

    localparam int W = 32;
    localparam longint CMAX = 64'hFFFF_FFFF;

    logic          clk;
    logic          reset_n;
    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic          clear;
    logic          locked;
    logic          err_pulse;
    logic [31:0]   err_cnt;
    logic [31:0]   word_cnt;
    logic          lock_lost;

    int            n_pass;
    int            n_total;
    int            pulses_seen;

    bit            gq[$];

    bit [W-1:0]    m_prev;
    bit            m_hv;
    int            m_state;
    int            m_good;
    int            m_bad;
    bit            m_lost;
    longint        m_errs;
    longint        m_words;
    int            m_pulses;

    xcvr_prbs_checker #(
        .DATA_W     (W),
        .PRBS_SEL   (31),
        .LOCK_CNT   (16),
        .UNLOCK_CNT (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .word_cnt  (word_cnt),
        .lock_lost (lock_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_pulse === 1'b1) pulses_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Serial-order PRBS31 source: s[n] = s[n-31] ^ s[n-28].
    function automatic bit [W-1:0] gen_word();
        bit [W-1:0] w;
        bit b;
        for (int i = 0; i < W; i++) begin
            b = gq[0] ^ gq[3];
            gq.push_back(b);
            void'(gq.pop_front());
            w[i] = b;
        end
        return w;
    endfunction

    function automatic int count_err(input bit [W-1:0] p,
                                     input bit [W-1:0] c);
        bit s[2*W];
        int e;
        for (int i = 0; i < W; i++) begin
            s[i]     = p[i];
            s[W + i] = c[i];
        end
        e = 0;
        for (int k = W; k < 2 * W; k++)
            if (s[k] != (s[k-31] ^ s[k-28])) e++;
        return e;
    endfunction

    task automatic m_reset();
        m_prev = '0; m_hv = 0; m_state = 0; m_good = 0; m_bad = 0;
        m_lost = 0; m_errs = 0; m_words = 0;
    endtask

    task automatic m_step(input bit [W-1:0] cur);
        int e;
        bit bad;
        if (!m_hv) begin
            m_hv = 1;
            m_prev = cur;
            return;
        end
        e = count_err(m_prev, cur);
        m_prev = cur;
        bad = (e != 0) || (m_state != 2 && cur == 0);
        if (m_state == 2) begin
            m_words = (m_words + 1 > CMAX) ? CMAX : m_words + 1;
            m_errs = (m_errs + e > CMAX) ? CMAX : m_errs + e;
            if (bad) begin
                m_pulses++;
                m_bad++;
                if (m_bad >= 4) begin
                    m_state = 0; m_lost = 1; m_bad = 0; m_good = 0;
                end
            end else m_bad = 0;
        end else if (bad) begin
            m_state = 0; m_good = 0;
        end else begin
            m_good = (m_state == 0) ? 1 : m_good + 1;
            m_state = 1;
            if (m_good >= 16) begin
                m_state = 2; m_bad = 0;
            end
        end
    endtask

    // Call at a negedge; leaves the bench at the next negedge.
    task automatic drive(input bit [W-1:0] d, input bit clr);
        rx_data = d;
        rx_valid = 1'b1;
        clear = clr;
        @(negedge clk);
        rx_valid = 1'b0;
        clear = 1'b0;
        if (clr) m_reset();
        else m_step(d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_locked"}, {31'd0, locked}, {31'd0, m_state == 2});
        chk({tag, "_err"}, err_cnt, m_errs[31:0]);
        chk({tag, "_words"}, word_cnt, m_words[31:0]);
        chk({tag, "_lost"}, {31'd0, lock_lost}, {31'd0, m_lost});
    endtask

    initial begin
        bit [W-1:0] w;
        logic [31:0] e0;
        int p0;
        int mp0;
        n_pass = 0; n_total = 0; pulses_seen = 0; m_pulses = 0;
        reset_n = 1'b0; rx_data = '0; rx_valid = 1'b0; clear = 1'b0;
        m_reset();
        for (int i = 0; i < 31; i++) gq.push_back(bit'($urandom_range(0, 1)));
        gq[7] = 1'b1;
        #23;
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_pulse", {31'd0, err_pulse}, 32'd0);
        chk("rst_err", err_cnt, 32'd0);
        chk("rst_words", word_cnt, 32'd0);
        chk("rst_lost", {31'd0, lock_lost}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);

        for (int k = 1; k <= 17; k++) begin
            drive(gen_word(), 1'b0);
            idle(2);
            chk($sformatf("acq_w%0d", k), {31'd0, locked},
                {31'd0, k >= 17});
        end
        for (int k = 0; k < 83; k++) drive(gen_word(), 1'b0);
        idle(2);
        chk("clean_err0", err_cnt, 32'd0);
        chk("clean_words", word_cnt, 32'd83);
        chk_model("clean");

        e0 = err_cnt; p0 = pulses_seen; mp0 = m_pulses;
        drive(gen_word() ^ (32'd1 << 5), 1'b0);
        drive(gen_word(), 1'b0);
        drive(gen_word(), 1'b0);
        idle(2);
        chk("flip_err3", err_cnt - e0, 32'd3);
        chk("flip_pulses", pulses_seen - p0, m_pulses - mp0);
        chk_model("flip");

        for (int k = 0; k < 4; k++) drive($urandom, 1'b0);
        idle(2);
        chk("loss_locked", {31'd0, locked}, 32'd0);
        chk("loss_lost", {31'd0, lock_lost}, 32'd1);
        chk_model("loss");
        for (int k = 1; k <= 17; k++) begin
            drive(gen_word(), 1'b0);
            idle(2);
            chk($sformatf("relock_w%0d", k), {31'd0, locked},
                {31'd0, m_state == 2});
        end
        chk("relock_up", {31'd0, locked}, 32'd1);
        chk("relock_lost", {31'd0, lock_lost}, 32'd1);

        e0 = err_cnt;
        for (int k = 0; k < 30; k++) begin
            drive(gen_word(), 1'b0);
            idle($urandom_range(1, 10));
        end
        idle(2);
        chk("gap_err", err_cnt, e0);
        chk_model("gap");

        drive($urandom | 32'h1, 1'b1);
        chk("clr_err", err_cnt, 32'd0);
        chk("clr_words", word_cnt, 32'd0);
        chk("clr_lost", {31'd0, lock_lost}, 32'd0);
        chk("clr_locked", {31'd0, locked}, 32'd0);
        idle(2);
        chk_model("clr_after");

        for (int k = 0; k < 17; k++) drive(gen_word(), 1'b0);
        idle(2);
        chk_model("postclr");
        force dut.r_err_cnt = 32'hFFFF_FFFD;
        force dut.r_word_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_err_cnt;
        release dut.r_word_cnt;
        m_errs = 64'hFFFF_FFFD;
        m_words = 64'hFFFF_FFFE;
        @(negedge clk);
        drive(gen_word() ^ (32'd1 << 5), 1'b0);
        for (int k = 0; k < 3; k++) drive(gen_word(), 1'b0);
        idle(2);
        chk("sat_err", err_cnt, 32'hFFFF_FFFF);
        chk("sat_words", word_cnt, 32'hFFFF_FFFF);
        chk_model("sat");

        rx_data = gen_word();
        rx_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_locked", {31'd0, locked}, 32'd0);
        chk("mrst_pulse", {31'd0, err_pulse}, 32'd0);
        chk("mrst_err", err_cnt, 32'd0);
        chk("mrst_words", word_cnt, 32'd0);
        chk("mrst_lost", {31'd0, lock_lost}, 32'd0);
        rx_valid = 1'b0;
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        chk_model("end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
